// File: rtl/rgb_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rgb_seq_pkg
// Description : Shared state encoding, address-width helper and palette entry
//               field layout for the RGB fade sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package rgb_seq_pkg;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_FADE = 2'd1;
    localparam logic [1:0] c_HOLD = 2'd2;

    // Field slots inside a packed palette entry {hold, B, G, R}.
    localparam int c_FIELD_R    = 0;
    localparam int c_FIELD_G    = 1;
    localparam int c_FIELD_B    = 2;
    localparam int c_FIELD_HOLD = 3;

    function automatic int calcAw(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    function automatic int fieldOffset(input int field, input int n);
        return field * n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running 0..COUNT-1 divider producing a one-cycle tick.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int COUNT = 20000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_run,
    output logic o_tick
);

    localparam int              c_CW   = (COUNT > 2) ? $clog2(COUNT) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(COUNT - 1);

    logic [c_CW-1:0] r_count;

    // Not gated by i_clr: the sequencer's clear request is itself derived from the tick.
    assign o_tick = i_run && (r_count == c_LAST);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_run) begin
            r_count <= (r_count == c_LAST) ? '0 : r_count + c_CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rgb_fade_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rgb_fade_sequencer
// Description : Steps an RGB LED through a programmable palette with linear
//               per-tick fades and per-entry hold times.
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_fade_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int N              = 8,
    parameter int DEPTH          = 4,
    parameter int STEP_CLK_COUNT = 20000,
    parameter int HOLD_W         = 8,
    localparam int AW            = calcAw(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_loop,
    input  logic [AW-1:0]     i_lastIdx,
    input  logic              i_wrEn,
    input  logic [AW-1:0]     i_wrAddr,
    input  logic [N-1:0]      i_wrR,
    input  logic [N-1:0]      i_wrG,
    input  logic [N-1:0]      i_wrB,
    input  logic [HOLD_W-1:0] i_wrHold,
    output logic [N-1:0]      o_ledRDutyCycle,
    output logic [N-1:0]      o_ledGDutyCycle,
    output logic [N-1:0]      o_ledBDutyCycle,
    output logic              o_en,
    output logic              o_busy,
    output logic [AW-1:0]     o_idx,
    output logic              o_done
);

    localparam int            c_ENTRY_W  = 3 * N + HOLD_W;
    localparam int            c_OFF_R    = fieldOffset(c_FIELD_R, N);
    localparam int            c_OFF_G    = fieldOffset(c_FIELD_G, N);
    localparam int            c_OFF_B    = fieldOffset(c_FIELD_B, N);
    localparam int            c_OFF_HOLD = fieldOffset(c_FIELD_HOLD, N);
    localparam logic [AW-1:0] c_MAX_IDX  = AW'(DEPTH - 1);

    logic [c_ENTRY_W-1:0] r_palette [DEPTH];
    logic [1:0]           r_state;
    logic [N-1:0]         r_dutyR, r_dutyG, r_dutyB;
    logic                 r_en, r_busy, r_done;
    logic [AW-1:0]        r_idx, r_lastIdx;
    logic [HOLD_W-1:0]    r_holdCnt;

    logic [c_ENTRY_W-1:0] w_entry;
    logic [N-1:0]         w_tgtR, w_tgtG, w_tgtB;
    logic [N-1:0]         w_nextR, w_nextG, w_nextB;
    logic [HOLD_W-1:0]    w_hold;
    logic                 w_tick, w_startOk, w_advance, w_clr, w_run, w_atTarget;

    function automatic logic [N-1:0] stepToward(input logic [N-1:0] cur, input logic [N-1:0] tgt);
        if (cur < tgt)      return cur + N'(1);
        else if (cur > tgt) return cur - N'(1);
        else                return cur;
    endfunction

    // Targets are read live so a write to the active entry retargets the fade.
    assign w_entry    = r_palette[r_idx];
    assign w_tgtR     = w_entry[c_OFF_R +: N];
    assign w_tgtG     = w_entry[c_OFF_G +: N];
    assign w_tgtB     = w_entry[c_OFF_B +: N];
    assign w_hold     = w_entry[c_OFF_HOLD +: HOLD_W];
    assign w_nextR    = stepToward(r_dutyR, w_tgtR);
    assign w_nextG    = stepToward(r_dutyG, w_tgtG);
    assign w_nextB    = stepToward(r_dutyB, w_tgtB);
    assign w_atTarget = (w_nextR == w_tgtR) && (w_nextG == w_tgtG) && (w_nextB == w_tgtB);

    assign w_startOk  = i_start && !i_stop && (r_state == c_IDLE);
    assign w_advance  = (r_state == c_HOLD) && w_tick && (r_holdCnt == '0);
    assign w_clr      = w_startOk || i_stop || w_advance;
    assign w_run      = (r_state != c_IDLE);

    tick_prescaler #(
        .COUNT (STEP_CLK_COUNT)
    ) u_prescaler (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_clr),
        .i_run  (w_run),
        .o_tick (w_tick)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int e = 0; e < DEPTH; e++) r_palette[e] <= '0;
        end else if (i_wrEn && (int'(i_wrAddr) < DEPTH)) begin
            r_palette[i_wrAddr] <= {i_wrHold, i_wrB, i_wrG, i_wrR};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= c_IDLE;
            r_dutyR   <= '0;
            r_dutyG   <= '0;
            r_dutyB   <= '0;
            r_en      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_idx     <= '0;
            r_lastIdx <= '0;
            r_holdCnt <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_stop) begin
                r_state <= c_IDLE;
                r_dutyR <= '0;
                r_dutyG <= '0;
                r_dutyB <= '0;
                r_en    <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (i_start) begin
                            r_state   <= c_FADE;
                            r_idx     <= '0;
                            r_busy    <= 1'b1;
                            r_en      <= 1'b1;
                            r_lastIdx <= (int'(i_lastIdx) >= DEPTH) ? c_MAX_IDX : i_lastIdx;
                        end
                    end
                    c_FADE: begin
                        if (w_tick) begin
                            r_dutyR <= w_nextR;
                            r_dutyG <= w_nextG;
                            r_dutyB <= w_nextB;
                            if (w_atTarget) begin
                                r_state   <= c_HOLD;
                                r_holdCnt <= w_hold;
                            end
                        end
                    end
                    c_HOLD: begin
                        if (w_tick) begin
                            if (r_holdCnt != '0) begin
                                r_holdCnt <= r_holdCnt - HOLD_W'(1);
                            end else if (r_idx < r_lastIdx) begin
                                r_idx   <= r_idx + AW'(1);
                                r_state <= c_FADE;
                            end else if (i_loop) begin
                                r_idx   <= '0;
                                r_state <= c_FADE;
                            end else begin
                                r_state <= c_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

    assign o_ledRDutyCycle = r_dutyR;
    assign o_ledGDutyCycle = r_dutyG;
    assign o_ledBDutyCycle = r_dutyB;
    assign o_en            = r_en;
    assign o_busy          = r_busy;
    assign o_idx           = r_idx;
    assign o_done          = r_done;

endmodule
`default_nettype wire

// File: doc/rgb_fade_sequencer.md
Name: rgb_fade_sequencer

Overview:
- Autonomous colour sequencer driving the duty-cycle inputs and enable of the RGB LED controller.
- Holds a small programmable palette of colours. Each entry has an R/G/B target and a hold time.
- Steps through the palette with linear fades: each channel moves by 1 LSB per fade tick. It then holds each colour for a programmable number of ticks.
- Sits between the register/control interface and the three-channel PWM LED controller.

Parameters:
- N, 8, duty-cycle width; must match the LED controller's N.
- DEPTH, 4, number of palette entries (≥2).
- STEP_CLK_COUNT, 20000, clock cycles per fade/hold tick (≥2).
- HOLD_W, 8, width of the per-entry hold count, in ticks.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  asynchronous, active-low reset.
- i_start  input  1  single-cycle pulse; starts the sequence from entry 0.
- i_stop  input  1  single-cycle pulse; aborts the sequence and blanks the LED.
- i_loop  input  1  1 = wrap from the last entry to entry 0; 0 = stop after the last entry.
- i_lastIdx  input  AW  index of the last active entry; AW = max(1, clog2(DEPTH)).
- i_wrEn  input  1  palette write strobe.
- i_wrAddr  input  AW  palette entry index to write.
- i_wrR, i_wrG, i_wrB  input  N each  target colour for the written entry.
- i_wrHold  input  HOLD_W  hold ticks for the written entry.
- o_ledRDutyCycle, o_ledGDutyCycle, o_ledBDutyCycle  output  N each  current duty cycles.
- o_en  output  1  LED controller enable.
- o_busy  output  1  high while in FADE or HOLD.
- o_idx  output  AW  current palette entry.
- o_done  output  1  one-cycle pulse when a non-looping sequence completes.

Behaviour:
- Reset (async assert, sync release):
  - All duties 0; o_en, o_busy, o_done 0; o_idx 0; state IDLE.
  - Prescaler, hold counter and every palette entry cleared to 0.
- Palette writes:
  - On i_wrEn, entry i_wrAddr takes {R,G,B,hold} at the clock edge. Writes are accepted in any state.
  - i_wrAddr ≥ DEPTH is ignored.
  - The fade target is read live from the palette, so a write to the active entry retargets the fade on the next tick.
- i_lastIdx is sampled into a register on an accepted start; values ≥ DEPTH are clamped to DEPTH-1.
- Prescaler:
  - Runs only in FADE/HOLD and counts 0..STEP_CLK_COUNT-1.
  - The tick is asserted for one cycle when the count equals STEP_CLK_COUNT-1; the count then wraps to 0.
  - Cleared on start, on stop, and on every entry transition.
- States and transitions:
  - IDLE: i_start → FADE. Sets o_idx=0, o_busy=1, o_en=1 on the next edge. Duties begin from their current values.
  - FADE, on each tick: each channel steps +1 if below its target, −1 if above, unchanged if equal. Steps saturate at the target, never overshoot and never wrap.
  - FADE → HOLD: when all three post-step values equal their targets, load holdCnt with the entry's hold. An entry equal to the current colour therefore leaves FADE on its first tick. A fade of distance D takes max(D,1) ticks.
  - HOLD, on each tick: if holdCnt==0, advance; else decrement. A hold of H lasts H+1 ticks.
- Advance:
  - If o_idx < the latched last index: o_idx+1, go to FADE.
  - Else if i_loop: o_idx=0, go to FADE.
  - Else: go to IDLE, o_busy=0, o_done=1 for one cycle. Duties are retained and o_en stays 1.
- i_stop, in any state: next edge gives IDLE, duties 0, o_en 0, o_busy 0, prescaler cleared; o_done is not pulsed.
- Priority and edge cases:
  - i_stop beats i_start in the same cycle.
  - i_start while busy is ignored.
  - i_loop is sampled at each advance.
- Latency: all outputs are registered. The first duty change appears STEP_CLK_COUNT cycles after the start edge.

Decomposition:
- Shared package rgb_seq_pkg holds:
  - state encoding (IDLE/FADE/HOLD);
  - the AW derivation function;
  - palette entry field offsets.
- Sub-module tick_prescaler has parameter COUNT and ports i_clk, i_rst, i_clr, i_run, o_tick.
- Palette registers, FSM and the three step-toward comparators stay in the top level.

Test Plan:
All scenarios use STEP_CLK_COUNT=4 and DEPTH=4.
- Reset: assert i_rst=0 with no clock running → all outputs 0 immediately. After release, o_busy stays 0 with no start.
- Single entry: entry0=(3,0,0), hold=1, lastIdx=0, loop=0, start → R=1,2,3 at 4, 8, 12 cycles after the start edge. Hold spans ticks 4–5. o_done pulses with the tick at cycle 20, then o_busy=0, R stays 3, o_en=1.
- Loop: entry0=(2,0,0) h0, entry1=(0,0,2) h0, lastIdx=1, loop=1:
  - R ramps 1,2, then o_idx→1.
  - R falls 1,0 while B rises 1,2, then o_idx→0.
  - The pattern repeats with no o_done.
- Stop mid-fade: at R=2 of a ramp to 200, pulse i_stop → next edge gives duties 0, o_en 0, o_busy 0. A following start ramps from 0.
- Retarget: entry0=(10,0,0), write entry0=(1,0,0) at R=4 → R steps 3,2,1, then HOLD.
- Edge cases:
  - Start and stop in the same cycle → remains IDLE.
  - Entry equal to the current colour → HOLD after 1 tick.
  - i_wrAddr=5 with DEPTH=4 → palette unchanged.
